// File: rtl/ctech_lib_pg_seq_pkg.sv
// ctech_lib_pg_seq_pkg: shared state encoding and counter widths for the power-gate sequencer
package ctech_lib_pg_seq_pkg;

    typedef enum logic [2:0] {
        PG_OFF     = 3'd0,
        PG_UP_EN   = 3'd1,
        PG_UP_WAIT = 3'd2,
        PG_ON      = 3'd3,
        PG_DN_DIS  = 3'd4,
        PG_DN_WAIT = 3'd5,
        PG_ERR     = 3'd6
    } pg_seq_state_t;

    localparam int PG_SCNT_W     = 8;
    localparam int PG_TCNT_W_MAX = 11;

endpackage

// File: rtl/ctech_lib_pg_seq_cnt.sv
// ctech_lib_pg_seq_cnt: saturating up-counter with synchronous clear and asynchronous reset
module ctech_lib_pg_seq_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // count up while enabled, hold at all-ones so a long wait never wraps back to zero
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;

endmodule

// File: rtl/ctech_lib_pg_seq.sv
// ctech_lib_pg_seq: staggered power-gate enable sequencer, one domain at a time with ack handshake
module ctech_lib_pg_seq #(
    parameter int NUM_DOM     = 4,
    parameter int STAGGER_CYC = 8,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pwr_req,
    input  logic [NUM_DOM-1:0] pg_ack,
    output logic [NUM_DOM-1:0] pg_en,
    output logic               pwr_ok,
    output logic               pwr_err,
    output logic               busy
);

    import ctech_lib_pg_seq_pkg::*;

    localparam int IW = $clog2(NUM_DOM);
    localparam int TW = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [IW-1:0]        LAST  = IW'(NUM_DOM - 1);
    localparam logic [PG_SCNT_W-1:0] S_LIM = PG_SCNT_W'(STAGGER_CYC - 1);
    localparam logic [TW-1:0]        T_LIM = TW'(ACK_TIMEOUT - 1);

    pg_seq_state_t        state, state_n;
    logic [IW-1:0]        idx, idx_n;
    logic [NUM_DOM-1:0]   pg_en_n, one_hot;
    logic [PG_SCNT_W-1:0] scnt;
    logic [TW-1:0]        tcnt;
    logic                 cnt_clr, cnt_inc, ack_i, s_done, t_done;

    assign one_hot = NUM_DOM'(1) << idx;
    assign ack_i   = pg_ack[idx];
    assign cnt_clr = state == PG_UP_EN || state == PG_DN_DIS;
    assign cnt_inc = state == PG_UP_WAIT || state == PG_DN_WAIT;
    assign s_done  = scnt >= S_LIM;
    assign t_done  = tcnt >= T_LIM;

    ctech_lib_pg_seq_cnt #(.W(PG_SCNT_W)) u_scnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (scnt)
    );

    ctech_lib_pg_seq_cnt #(.W(TW)) u_tcnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (tcnt)
    );

    // sequencing decisions: ascending power-up, descending power-down, abort and error exits
    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            PG_OFF:
                if (pwr_req) begin
                    state_n = PG_UP_EN;
                    idx_n   = '0;
                end
            PG_UP_EN:
                state_n = PG_UP_WAIT;
            PG_UP_WAIT:
                if (!pwr_req) state_n = PG_DN_DIS;
                else if (t_done && !ack_i) state_n = PG_ERR;
                else if (ack_i && s_done) begin
                    state_n = idx == LAST ? PG_ON : PG_UP_EN;
                    idx_n   = idx == LAST ? idx : idx + 1'b1;
                end
            PG_ON:
                if (!(&pg_ack)) state_n = PG_ERR;
                else if (!pwr_req) begin
                    state_n = PG_DN_DIS;
                    idx_n   = LAST;
                end
            PG_DN_DIS:
                state_n = PG_DN_WAIT;
            PG_DN_WAIT:
                if (t_done && ack_i) state_n = PG_ERR;
                else if (!ack_i && s_done) begin
                    state_n = idx == '0 ? PG_OFF : PG_DN_DIS;
                    idx_n   = idx == '0 ? idx : idx - 1'b1;
                end
            PG_ERR:
                if (!pwr_req) begin
                    state_n = PG_OFF;
                    idx_n   = '0;
                end
            default: begin
                state_n = PG_OFF;
                idx_n   = '0;
            end
        endcase
    end

    // enables grow or shrink one bit per enable/disable step; entering ERR drops every domain at once
    always_comb begin
        pg_en_n = state_n == PG_ERR   ? '0 :
                  state == PG_UP_EN   ? pg_en | one_hot :
                  state == PG_DN_DIS  ? pg_en & ~one_hot : pg_en;
    end

    // state, index and all outputs are registered from the next-state decision
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= PG_OFF;
            idx     <= '0;
            pg_en   <= '0;
            pwr_ok  <= 1'b0;
            pwr_err <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            pg_en   <= pg_en_n;
            pwr_ok  <= state_n == PG_ON;
            pwr_err <= state_n == PG_ERR;
            busy    <= state_n == PG_UP_EN || state_n == PG_UP_WAIT ||
                       state_n == PG_DN_DIS || state_n == PG_DN_WAIT;
        end

endmodule

// File: tb/tb_ctech_lib_pg_seq.sv
// tb_ctech_lib_pg_seq: directed scoreboard bench for the power-gate sequencer
module tb_ctech_lib_pg_seq;

    logic       clk = 1'b0;
    logic       rst, pwr_req;
    logic [3:0] pg_ack, pg_en, kill, d1, d2, d3;
    logic       pwr_ok, pwr_err, busy;
    logic [3:0] last_en = '0;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    typedef struct {
        logic [3:0] v;
        int         t;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];

    ctech_lib_pg_seq #(
        .NUM_DOM     (4),
        .STAGGER_CYC (8),
        .ACK_TIMEOUT (64)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pwr_req (pwr_req),
        .pg_ack  (pg_ack),
        .pg_en   (pg_en),
        .pwr_ok  (pwr_ok),
        .pwr_err (pwr_err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // each domain acks three cycles after its enable changes; kill holds chosen acks low
    always @(posedge clk or posedge rst)
        if (rst) begin
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
        end else begin
            d1 <= pg_en;
            d2 <= d1;
            d3 <= d2;
        end

    assign pg_ack = d3 & ~kill;

    // record every pg_en change with the cycle it was first seen
    always @(negedge clk)
        if (pg_en !== last_en) begin
            obs_q.push_back('{pg_en, cyc});
            last_en <= pg_en;
        end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [3:0] v, input int t);
        exp_q.push_back('{v, t});
    endtask

    task automatic drain(input string tag);
        chk({tag, " count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, " pg_en"}, o.v, e.v);
            chk({tag, " cycle"}, o.t, e.t);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic to_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int c0, a, r;
        rst     = 1'b1;
        pwr_req = 1'b0;
        kill    = '0;
        repeat (2) @(negedge clk);
        chk("reset pg_en", pg_en, 0);
        chk("reset pwr_ok", pwr_ok, 0);
        chk("reset pwr_err", pwr_err, 0);
        chk("reset busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        c0 = cyc;
        pwr_req = 1'b1;
        push(4'h1, c0 + 2);
        push(4'h3, c0 + 11);
        push(4'h7, c0 + 20);
        push(4'hF, c0 + 29);
        repeat (2) @(negedge clk);
        chk("up busy", busy, 1);
        for (int i = 0; i < 200 && pwr_ok !== 1'b1; i++) @(negedge clk);
        chk("up pwr_ok", pwr_ok, 1);
        chk("up pwr_ok cycle", cyc, c0 + 37);
        chk("up busy done", busy, 0);
        repeat (2) @(negedge clk);
        drain("up");

        c0 = cyc;
        pwr_req = 1'b0;
        push(4'h7, c0 + 2);
        push(4'h3, c0 + 11);
        push(4'h1, c0 + 20);
        push(4'h0, c0 + 29);
        @(negedge clk);
        chk("dn pwr_ok", pwr_ok, 0);
        chk("dn busy", busy, 1);
        for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge clk);
        chk("dn off cycle", cyc, c0 + 37);
        chk("dn busy done", busy, 0);
        repeat (2) @(negedge clk);
        drain("dn");

        repeat (5) @(negedge clk);
        c0 = cyc;
        pwr_req = 1'b1;
        push(4'h1, c0 + 2);
        push(4'h3, c0 + 11);
        to_cyc(c0 + 13);
        a = cyc;
        pwr_req = 1'b0;
        push(4'h1, a + 2);
        push(4'h0, a + 11);
        for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge clk);
        chk("abort off cycle", cyc, a + 19);
        chk("abort pwr_err", pwr_err, 0);
        repeat (2) @(negedge clk);
        drain("abort");

        repeat (5) @(negedge clk);
        kill = 4'b0100;
        c0 = cyc;
        pwr_req = 1'b1;
        push(4'h1, c0 + 2);
        push(4'h3, c0 + 11);
        push(4'h7, c0 + 20);
        push(4'h0, c0 + 84);
        for (int i = 0; i < 200 && pwr_err !== 1'b1; i++) @(negedge clk);
        chk("tmo pwr_err", pwr_err, 1);
        chk("tmo cycle", cyc, c0 + 84);
        chk("tmo pg_en", pg_en, 0);
        chk("tmo busy", busy, 0);
        repeat (10) @(negedge clk);
        chk("tmo sticky", pwr_err, 1);
        drain("tmo");
        pwr_req = 1'b0;
        @(negedge clk);
        chk("tmo clear", pwr_err, 0);
        chk("tmo off busy", busy, 0);
        kill = '0;

        repeat (5) @(negedge clk);
        c0 = cyc;
        pwr_req = 1'b1;
        push(4'h1, c0 + 2);
        push(4'h3, c0 + 11);
        push(4'h7, c0 + 20);
        push(4'hF, c0 + 29);
        for (int i = 0; i < 200 && pwr_ok !== 1'b1; i++) @(negedge clk);
        chk("loss up pwr_ok", pwr_ok, 1);
        repeat (2) @(negedge clk);
        drain("loss up");
        a = cyc;
        kill = 4'b0001;
        push(4'h0, a + 1);
        @(negedge clk);
        chk("loss pwr_err", pwr_err, 1);
        chk("loss pwr_ok", pwr_ok, 0);
        chk("loss pg_en", pg_en, 0);
        pwr_req = 1'b0;
        kill = '0;
        @(negedge clk);
        chk("loss clear", pwr_err, 0);
        repeat (2) @(negedge clk);
        drain("loss");

        repeat (5) @(negedge clk);
        c0 = cyc;
        pwr_req = 1'b1;
        push(4'h1, c0 + 2);
        push(4'h3, c0 + 11);
        push(4'h7, c0 + 20);
        to_cyc(c0 + 22);
        drain("pre-rst");
        #2 rst = 1'b1;
        #1;
        chk("arst pg_en", pg_en, 0);
        chk("arst pwr_ok", pwr_ok, 0);
        chk("arst pwr_err", pwr_err, 0);
        chk("arst busy", busy, 0);
        repeat (2) @(negedge clk);
        obs_q.delete();
        rst = 1'b0;
        r = cyc;
        push(4'h1, r + 2);
        push(4'h3, r + 11);
        to_cyc(r + 13);
        drain("restart");
        pwr_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ctech_lib_pg_seq.md
Name: ctech_lib_pg_seq

Overview:
- Staggered power-gate enable sequencer for NUM_DOM buffered switch domains, each a chain of library buffer cells driving sleep transistors.
- Turns domains on in ascending order and off in descending order, one at a time.
- Waits for each domain's returned acknowledge before moving to the next, which limits inrush and di/dt.
- Sits between the power-management request logic and the ctech switch-buffer chains; reports when power is good and when an acknowledge times out.

Parameters:
- NUM_DOM, 4, number of gated domains (2..16)
- STAGGER_CYC, 8, minimum cycles between enabling or disabling successive domains (1..255)
- ACK_TIMEOUT, 64, maximum cycles to wait for a domain ack before declaring an error (must be > STAGGER_CYC, up to 1023)

Ports:
- clk  in  1  block clock
- rst  in  1  reset; asynchronous, active-high
- pwr_req  in  1  level request: 1 = all domains on, 0 = all off
- pg_ack  in  NUM_DOM  per-domain ack returned from the end of each buffer chain; treated as synchronous to clk
- pg_en  out  NUM_DOM  per-domain switch enable, registered
- pwr_ok  out  1  1 while every domain is on and acked
- pwr_err  out  1  sticky ack-timeout error
- busy  out  1  1 in any transitional state

Behaviour:
- Reset (async assert): state=OFF, pg_en=0, pwr_ok=0, pwr_err=0, busy=0, idx=0, counters=0. Deassertion is synchronous to clk at the integration level.
- States: OFF, UP_EN, UP_WAIT, ON, DN_DIS, DN_WAIT, ERR. All outputs registered.
- OFF:
  - pwr_req=1 -> UP_EN with idx=0.
  - pwr_req=0 -> stay.
- UP_EN (1 cycle):
  - set pg_en[idx]=1, clear stagger counter (scnt) and timeout counter (tcnt) -> UP_WAIT.
- UP_WAIT: scnt and tcnt increment each cycle, saturating. Priority order:
  - pwr_req=0 -> DN_DIS with idx unchanged; the just-enabled domain is switched off first.
  - tcnt reaches ACK_TIMEOUT-1 with pg_ack[idx]=0 -> ERR.
  - pg_ack[idx]=1 and scnt>=STAGGER_CYC-1:
    - if idx==NUM_DOM-1 -> ON;
    - else idx++ -> UP_EN.
- Minimum spacing between successive pg_en rising edges is STAGGER_CYC+1 cycles.
- ON:
  - pwr_ok=1.
  - pwr_req=0 -> DN_DIS with idx=NUM_DOM-1; pwr_ok drops on the same edge.
  - Any pg_ack bit falling while in ON sets pwr_err and goes to ERR.
- DN_DIS (1 cycle):
  - clear pg_en[idx], clear scnt/tcnt -> DN_WAIT.
- DN_WAIT:
  - tcnt expiry with pg_ack[idx]=1 -> ERR.
  - pg_ack[idx]=0 and scnt>=STAGGER_CYC-1:
    - if idx==0 -> OFF;
    - else idx-- -> DN_DIS.
  - pwr_req rising during power-down is ignored until OFF is reached. OFF then restarts power-up on the next cycle if pwr_req is still 1.
- ERR:
  - pg_en=0 (all domains dropped at once), pwr_err=1, pwr_ok=0, busy=0.
  - Exit to OFF only when pwr_req=0; pwr_err clears on that exit.
  - Only reset or pwr_req low clears the error.
- busy=1 in UP_EN, UP_WAIT, DN_DIS, DN_WAIT.
- Invariant outside ERR: pg_en is a thermometer code (bits 0..k set, rest clear).
- Reset mid-sequence: pg_en clears immediately; no ordered shutdown.
- Widths: idx is $clog2(NUM_DOM); scnt is 8 bits; tcnt is $clog2(ACK_TIMEOUT)+1 bits; both counters saturate and never wrap.

Decomposition:
- Package ctech_lib_pg_seq_pkg holds:
  - the state enum pg_seq_state_t (7 states, 3-bit);
  - counter width constants PG_SCNT_W=8 and PG_TCNT_W_MAX=11.
- One sub-module is natural: ctech_lib_pg_seq_cnt, a saturating counter with sync clear and async reset. It is instantiated twice, for scnt and tcnt.
- The state machine and the idx register stay in the top module.

Test Plan:
- Normal up, defaults (NUM_DOM=4, STAGGER_CYC=8), ack model returns each ack 3 cycles after its enable -> pg_en goes 0001,0011,0111,1111 with rising edges 9 cycles apart; pwr_ok=1 one cycle after the FSM sees pg_ack[3] while scnt>=7.
- Normal down from ON: pwr_req=0 -> pg_en goes 0111,0011,0001,0000 at the same spacing; pwr_ok falls the cycle after pwr_req falls; state reaches OFF with busy=0.
- Timeout: pg_ack[2] held 0 -> pwr_err=1 and pg_en=0000 exactly 64 cycles after pg_en[2] rose; pwr_err stays 1 until pwr_req=0, then clears and state=OFF.
- Abort up: drop pwr_req while in UP_WAIT for idx=1 (pg_en=0011) -> descending shutdown starting with domain 1; pg_en goes 0001 then 0000, with no further rising edges.
- Ack loss in ON: force pg_ack[0]=0 -> next cycle pwr_err=1, pwr_ok=0, pg_en=0000.
- Async reset asserted mid power-up with pg_en=0111 -> pg_en=0000 and all status outputs 0 before the next clk edge; after release with pwr_req=1, the sequence restarts at domain 0.
